fetch_pc_predictor: RTL

//  IF-stage PC generator and branch predictor that consumes the EX-stage branch-resolution interface
//  (prediction-correct flag, correct PC, actual outcome).

---
 rtl/fetch_pc_predictor_pkg.sv | 13 +
 rtl/fetch_pc_predictor_bht.sv | 29 ++
 rtl/fetch_pc_predictor.sv | 69 ++++++
 3 files changed

// File: rtl/fetch_pc_predictor_pkg.sv
// fetch_pc_predictor_pkg: opcodes, 2-bit counter encodings and immediate extraction for the fetch predictor
package fetch_pc_predictor_pkg;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;
  function automatic logic [31:0] b_imm(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] j_imm(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction
endpackage

// File: rtl/fetch_pc_predictor_bht.sv
// bht_2bit: table of 2-bit saturating counters, combinational read, synchronous update
module bht_2bit
  import fetch_pc_predictor_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  logic [1:0] mem [DEPTH];
  logic [1:0] cur;
  logic [1:0] upd;
  assign rd_ctr = mem[rd_idx];
  assign cur = mem[wr_idx];
  assign upd = wr_taken ? (cur == ST ? ST : cur + 2'd1) : (cur == SNT ? SNT : cur - 2'd1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= WNT;
    end else if (wr_en) begin
      mem[wr_idx] <= upd;
    end
  end
endmodule

// File: rtl/fetch_pc_predictor.sv
// fetch_pc_predictor: IF-stage PC register with predecode, BHT/JAL prediction and EX-driven redirect
module fetch_pc_predictor
  import fetch_pc_predictor_pkg::*;
#(
  parameter int              size      = 32,
  parameter int              BHT_DEPTH = 64,
  parameter logic [size-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic [size-1:0] instr_i,
  input  logic            ex_resolve_i,
  input  logic            ex_isValid_i,
  input  logic [size-1:0] ex_correct_pc_i,
  input  logic [size-1:0] ex_branch_pc_i,
  input  logic            ex_taken_i,
  input  logic            ex_is_cond_i,
  output logic [size-1:0] pc_o,
  output logic [size-1:0] pc_plus_o,
  output logic            predicted_mpc_o,
  output logic            flush_o,
  output logic [15:0]     mispredict_cnt_o
);
  localparam int IDX_W = $clog2(BHT_DEPTH);
  logic [1:0]      ctr;
  logic [6:0]      opcode;
  logic            is_br;
  logic            is_jal;
  logic            taken;
  logic [size-1:0] imm;
  logic [size-1:0] target;
  logic [size-1:0] pc_next;
  logic            unused_bits;
  bht_2bit #(.DEPTH(BHT_DEPTH), .IDX_W(IDX_W)) u_bht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (pc_o[IDX_W+1:2]),
    .rd_ctr   (ctr),
    .wr_en    (ex_resolve_i & ex_is_cond_i),
    .wr_idx   (ex_branch_pc_i[IDX_W+1:2]),
    .wr_taken (ex_taken_i)
  );
  assign unused_bits = ^{ex_branch_pc_i[size-1:IDX_W+2], ex_branch_pc_i[1:0], instr_i[size-1:7] == 0};
  always_comb begin
    opcode          = instr_i[6:0];
    is_br           = opcode == OPC_BRANCH;
    is_jal          = opcode == OPC_JAL;
    taken           = is_jal | (is_br & ctr[1]);
    imm             = is_jal ? size'($signed(j_imm(instr_i[31:0]))) : size'($signed(b_imm(instr_i[31:0])));
    target          = pc_o + imm;
    pc_plus_o       = pc_o + size'(4);
    flush_o         = ex_resolve_i & ~ex_isValid_i;
    predicted_mpc_o = taken & ~flush_o;
    // Redirect outranks stall so a mispredict is never lost behind a hazard
    pc_next         = flush_o ? ex_correct_pc_i :
                      stall_i ? pc_o :
                      taken   ? {target[size-1:2], 2'b00} : pc_plus_o;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_o             <= RESET_PC;
      mispredict_cnt_o <= '0;
    end else begin
      pc_o <= pc_next;
      if (flush_o && mispredict_cnt_o != 16'hFFFF) mispredict_cnt_o <= mispredict_cnt_o + 16'd1;
    end
  end
endmodule
